data_mem_responder: RTL and testbench

- Data-memory responder for the MEM stage of the pipelined CPU. It serves the stage's load and store requests.
- Accepts MemRead/MemWrite with ByteSel and SignExt, and performs word, halfword and byte accesses with little-endian lane selection.
- Inserts a configurable number of wait states and raises Stall to freeze the pipeline until Ready.
- Replaces the single-cycle combinational data memory in the MEM stage.

---
 rtl/data_mem_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory with configurable wait states.
// Serves word/half/byte loads and stores (little-endian lanes), raises Stall
// until the one-cycle Ready pulse, and drops misaligned accesses.
// Optional feature macro: DMEM_ERR_CNT_EN enables the saturating
// misaligned-access counter on ErrCount (tied to 0 when undefined).
//
// Handshake: the requester raises MemRead and/or MemWrite with stable
// Address/ByteSel/SignExt/WriteData and holds them until Ready. The request
// is captured on the first rising edge seen in IDLE. Ready is a one-cycle
// pulse in RESP; Stall stays high from the request cycle until RESP, so the
// pipeline advances on the RESP edge. No request is taken while in RESP.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  ByteSel,
    input  logic        SignExt,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Stall,
    output logic        Misaligned,
    output logic [7:0]  ErrCount,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AW    = ADDR_WIDTH + 2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       latch_en;
    logic       enter_resp;

    // Captured request
    logic          op_wr_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    bsel_q;
    logic          sext_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    // Effective request: live inputs while in IDLE (needed when WAIT_CYCLES=0),
    // the captured copy afterwards.
    logic          req;
    logic          cur_wr;
    logic [AW-1:0] cur_addr;
    logic [1:0]    cur_bsel;
    logic          cur_sext;
    logic [31:0]   cur_wdata;
    logic          cur_mis;
    logic          commit_we;

    logic [31:0] mem [DEPTH];
    logic [31:0] mem_word;
    logic [31:0] wr_word;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    logic unused_addr_bits;
    assign unused_addr_bits = ^Address[31:AW];

    assign req       = MemRead | MemWrite;
    assign cur_wr    = (state == S_IDLE) ? MemWrite : op_wr_q;
    assign cur_addr  = (state == S_IDLE) ? Address[AW-1:0] : addr_q;
    assign cur_bsel  = (state == S_IDLE) ? ByteSel : bsel_q;
    assign cur_sext  = (state == S_IDLE) ? SignExt : sext_q;
    assign cur_wdata = (state == S_IDLE) ? WriteData : wdata_q;
    assign dbg_state = state;

    // Alignment rule: words need [1:0]==0, halves need [0]==0, bytes always ok
    always_comb begin
        cur_mis = 1'b0;
        case (cur_bsel)
            2'b01:   cur_mis = cur_addr[0];
            2'b10:   cur_mis = 1'b0;
            default: cur_mis = (cur_addr[1:0] != 2'b00);
        endcase
    end

    // State register and wait counter
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic plus Stall/Ready decode
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        latch_en     = 1'b0;
        enter_resp   = 1'b0;
        Stall        = 1'b0;
        Ready        = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    Stall    = 1'b1;
                    latch_en = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                Stall = 1'b1;
                if (wait_cnt == 4'd0) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            S_RESP: begin
                Ready     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the request when it is accepted; a simultaneous read+write is a store
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            bsel_q  <= 2'b00;
            sext_q  <= 1'b0;
            wdata_q <= 32'd0;
        end else if (latch_en) begin
            op_wr_q <= MemWrite;
            addr_q  <= Address[AW-1:0];
            bsel_q  <= ByteSel;
            sext_q  <= SignExt;
            wdata_q <= WriteData;
        end
    end

    assign mem_word = mem[cur_addr[AW-1:2]];

    // Merge store data into the addressed lane(s) of the current word
    always_comb begin
        wr_word = mem_word;
        case (cur_bsel)
            2'b10: wr_word[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
            2'b01: begin
                if (cur_addr[1]) wr_word[31:16] = cur_wdata[15:0];
                else             wr_word[15:0]  = cur_wdata[15:0];
            end
            default: wr_word = cur_wdata;
        endcase
    end

    // Select and extend load data
    always_comb begin
        ld_byte = mem_word[{cur_addr[1:0], 3'b000} +: 8];
        ld_half = cur_addr[1] ? mem_word[31:16] : mem_word[15:0];
        case (cur_bsel)
            2'b10:   ld_word = {{24{ld_byte[7] & cur_sext}}, ld_byte};
            2'b01:   ld_word = {{16{ld_half[15] & cur_sext}}, ld_half};
            default: ld_word = mem_word;
        endcase
    end

    // Reset gates the commit so an aborted store never lands
    assign commit_we = enter_resp & cur_wr & ~cur_mis & ~Rst;

    // Memory array: not reset, written only on the edge entering RESP
    always_ff @(posedge Clk) begin
        if (commit_we) mem[cur_addr[AW-1:2]] <= wr_word;
    end

    // Load result and error flag, registered on the edge entering RESP
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ReadData <= 32'd0;
            err_q    <= 1'b0;
        end else if (enter_resp) begin
            err_q <= cur_mis;
            if (cur_mis)      ReadData <= 32'd0;
            else if (!cur_wr) ReadData <= ld_word;
        end
    end

    assign Misaligned = Ready & err_q;

`ifdef DMEM_ERR_CNT_EN
    logic [7:0] err_cnt;

    // Saturating count of misaligned responses
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            err_cnt <= 8'd0;
        end else if (Misaligned && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign ErrCount = err_cnt;
`else
    assign ErrCount = 8'd0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT_CYCLES=1 (a), one with
// WAIT_CYCLES=0 (b). A byte-level reference memory predicts load results;
// expected {Misaligned, ReadData} are queued at drive time and popped at Ready.
module tb_data_mem_responder;

    localparam int WAIT_A = 1;
    localparam int WAIT_B = 0;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst_a, rd_a, wr_a, se_a;
    logic [1:0]  bs_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        ready_a, stall_a, mis_a;
    logic [7:0]  errc_a;
    logic [1:0]  dbg_a;

    logic        rst_b, rd_b, wr_b, se_b;
    logic [1:0]  bs_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic        ready_b, stall_b, mis_b;
    logic [7:0]  errc_b;
    logic [1:0]  dbg_b;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WAIT_A)) dut_a (
        .Clk(Clk), .Rst(rst_a), .MemRead(rd_a), .MemWrite(wr_a), .ByteSel(bs_a),
        .SignExt(se_a), .Address(addr_a), .WriteData(wdata_a), .ReadData(rdata_a),
        .Ready(ready_a), .Stall(stall_a), .Misaligned(mis_a), .ErrCount(errc_a),
        .dbg_state(dbg_a)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WAIT_B)) dut_b (
        .Clk(Clk), .Rst(rst_b), .MemRead(rd_b), .MemWrite(wr_b), .ByteSel(bs_b),
        .SignExt(se_b), .Address(addr_b), .WriteData(wdata_b), .ReadData(rdata_b),
        .Ready(ready_b), .Stall(stall_b), .Misaligned(mis_b), .ErrCount(errc_b),
        .dbg_state(dbg_b)
    );

    // Scoreboard state
    logic [32:0] exp_qa[$];
    logic [32:0] exp_qb[$];
    logic [7:0]  ref_b [2][4096];
    logic [31:0] last_rd [2];
    int          err_exp [2];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] o_rdata(input int w);
        return (w == 0) ? rdata_a : rdata_b;
    endfunction
    function automatic logic o_ready(input int w);
        return (w == 0) ? ready_a : ready_b;
    endfunction
    function automatic logic o_stall(input int w);
        return (w == 0) ? stall_a : stall_b;
    endfunction
    function automatic logic o_mis(input int w);
        return (w == 0) ? mis_a : mis_b;
    endfunction
    function automatic logic [7:0] o_errc(input int w);
        return (w == 0) ? errc_a : errc_b;
    endfunction
    function automatic logic [1:0] o_dbg(input int w);
        return (w == 0) ? dbg_a : dbg_b;
    endfunction

    task automatic drive(input int w, input logic rd, input logic wr, input logic [1:0] bs,
                         input logic se, input logic [31:0] addr, input logic [31:0] wdata);
        if (w == 0) begin
            rd_a = rd; wr_a = wr; bs_a = bs; se_a = se; addr_a = addr; wdata_a = wdata;
        end else begin
            rd_b = rd; wr_b = wr; bs_b = bs; se_b = se; addr_b = addr; wdata_b = wdata;
        end
    endtask

    // Reference model: byte-addressed, 4 KiB per instance (ADDR_WIDTH=10)
    function automatic logic [31:0] model_load(input int w, input logic [1:0] bs,
                                               input logic se, input logic [11:0] a);
        logic [15:0] h;
        logic [7:0]  b;
        if (bs == 2'b10) begin
            b = ref_b[w][a];
            return se ? {{24{b[7]}}, b} : {24'd0, b};
        end else if (bs == 2'b01) begin
            h = {ref_b[w][a + 12'd1], ref_b[w][a]};
            return se ? {{16{h[15]}}, h} : {16'd0, h};
        end
        return {ref_b[w][a + 12'd3], ref_b[w][a + 12'd2], ref_b[w][a + 12'd1], ref_b[w][a]};
    endfunction

    task automatic model_store(input int w, input logic [1:0] bs, input logic [11:0] a,
                               input logic [31:0] d);
        ref_b[w][a] = d[7:0];
        if (bs != 2'b10) ref_b[w][a + 12'd1] = d[15:8];
        if (bs == 2'b00 || bs == 2'b11) begin
            ref_b[w][a + 12'd2] = d[23:16];
            ref_b[w][a + 12'd3] = d[31:24];
        end
    endtask

    // One request: predict, drive at a falling edge, wait for Ready, compare
    task automatic access(input int w, input logic rd, input logic wr, input logic [1:0] bs,
                          input logic se, input logic [31:0] addr, input logic [31:0] wdata);
        logic        mis;
        logic [31:0] exp;
        logic [32:0] e;
        int          cycles, stalls, lat;
        bit          got;
        lat = (w == 0) ? WAIT_A + 1 : WAIT_B + 1;
        if (bs == 2'b01)      mis = addr[0];
        else if (bs == 2'b10) mis = 1'b0;
        else                  mis = (addr[1:0] != 2'b00);
        if (mis)      exp = 32'd0;
        else if (wr)  exp = last_rd[w];
        else          exp = model_load(w, bs, se, addr[11:0]);
        if (!mis && wr) model_store(w, bs, addr[11:0], wdata);
        last_rd[w] = exp;
`ifdef DMEM_ERR_CNT_EN
        if (mis && err_exp[w] < 255) err_exp[w]++;
`endif
        if (w == 0) exp_qa.push_back({mis, exp});
        else        exp_qb.push_back({mis, exp});

        @(negedge Clk);
        drive(w, rd, wr, bs, se, addr, wdata);
        cycles = 0; stalls = 0; got = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (o_ready(w)) begin
                got = 1;
                break;
            end
            if (o_stall(w)) stalls++;
            cycles++;
            @(negedge Clk);
        end
        check("ready_seen", 32'(got), 32'd1);
        e = (w == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
        if (got) begin
            check("latency", cycles, lat);
            check("stall_cycles", stalls, lat);
            check("stall_in_resp", 32'(o_stall(w)), 32'd0);
            check("misaligned", 32'(o_mis(w)), 32'(e[32]));
            check("read_data", o_rdata(w), e[31:0]);
        end
    endtask

    // Drop the request and check the idle-side outputs one cycle after RESP
    task automatic release_bus(input int w);
        @(negedge Clk);
        drive(w, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        #1;
        check("ready_low", 32'(o_ready(w)), 32'd0);
        check("misaligned_low", 32'(o_mis(w)), 32'd0);
        check("err_count", 32'(o_errc(w)), 32'(err_exp[w]));
    endtask

    initial begin
        logic [1:0]  rbs;
        logic [31:0] raddr;
        int          op;

        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        last_rd = '{32'd0, 32'd0};
        err_exp = '{0, 0};
        repeat (2) @(negedge Clk);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            check("reset_state", 32'(o_dbg(w)), 32'd0);
            check("reset_rdata", o_rdata(w), 32'd0);
            check("reset_ready", 32'(o_ready(w)), 32'd0);
            check("reset_stall", 32'(o_stall(w)), 32'd0);
            check("reset_mis", 32'(o_mis(w)), 32'd0);
            check("reset_errc", 32'(o_errc(w)), 32'd0);
        end

        // Word store then load
        access(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF); release_bus(0);
        access(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);        release_bus(0);

        // Byte store into a zeroed word, then word/byte loads
        access(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0);        release_bus(0);
        access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'hFFFFFF80); release_bus(0);
        access(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);        release_bus(0);
        access(0, 1'b1, 1'b0, 2'b10, 1'b1, 32'h13, 32'h0);        release_bus(0);
        access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);        release_bus(0);

        // Half store into 0xAAAAAAAA, then loads
        access(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'hAAAAAAAA); release_bus(0);
        access(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234); release_bus(0);
        access(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);        release_bus(0);
        access(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);        release_bus(0);
        access(0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);        release_bus(0);

        // Misaligned word load/store and half load; memory must be untouched
        access(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);        release_bus(0);
        access(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFFF); release_bus(0);
        access(0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h13, 32'h0);        release_bus(0);
        access(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);        release_bus(0);

        // Read and write together behaves as a store
        access(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h24, 32'h13579BDF); release_bus(0);
        access(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h24, 32'h0);        release_bus(0);

        // Random mix over an initialised region
        for (int i = 0; i < 16; i++)
            access(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h40 + 32'(4 * i), $urandom);
        release_bus(0);
        for (int i = 0; i < 24; i++) begin
            op    = $urandom_range(0, 2);
            rbs   = 2'($urandom_range(0, 3));
            raddr = 32'h40 + 32'($urandom_range(0, 63));
            access(0, op != 1, op != 0, rbs, 1'($urandom_range(0, 1)), raddr, $urandom);
            release_bus(0);
        end

        // Reset during WAIT of a store: store must not commit
        access(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h30, 32'h11223344); release_bus(0);
        @(negedge Clk);
        drive(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h30, 32'h00000055);
        @(negedge Clk);
        #1;
        check("in_wait_state", 32'(dbg_a), 32'd1);
        rst_a = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        #1;
        check("rst_state", 32'(dbg_a), 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_mis", 32'(mis_a), 32'd0);
        check("rst_errc", 32'(errc_a), 32'd0);
        last_rd[0] = 32'd0;
        err_exp[0] = 0;
        @(negedge Clk);
        rst_a = 1'b0;
        access(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0);        release_bus(0);

        // Zero wait states: back-to-back requests and address aliasing
        access(1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 32'hCAFEF00D);
        access(1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h4, 32'h0BADC0DE);
        access(1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        access(1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
        access(1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0);
        access(1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h1006, 32'h0000BEEF);
        access(1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
        access(1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h5, 32'h0);
        release_bus(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
